fp8_mult_collect: RTL and testbench

- Downstream stage of the combinational fp8 multiplier.
- Accepts each product (8-bit fp8 result plus 5-bit flags {invalid, divzero, overflow, underflow, inexact}) over a valid/ready handshake and buffers it in a small FIFO.
- Presents buffered products to the consumer over a second valid/ready handshake.
- Keeps IEEE-style sticky exception flags, a saturating product counter and a maskable trap output for the control/CSR side.

---
 rtl/fp8_mult_collect.sv | 93 +++++++++
 tb/tb_fp8_mult_collect.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_mult_collect.sv
// fp8_mult_collect: collects fp8 multiplier products into a small FIFO and
// presents them to a consumer. It also keeps sticky exception flags, a
// saturating accepted-product counter and a maskable trap level.
module fp8_mult_collect #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_result,
  input  logic [4:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic [4:0]       out_flags,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  input  logic [4:0]       trap_en,
  output logic             trap,
  output logic [CNT_W-1:0] count,
  input  logic             cnt_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [4:0]       fflags_q, fflags_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [12:0]      mem_q [DEPTH];

  logic full, empty, push, pop;

  // Handshake qualifiers depend only on registered occupancy, so in_ready
  // never sees out_ready or in_valid combinationally.
  assign full     = (occ_q == FULL_OCC);
  assign empty    = (occ_q == '0);
  assign in_ready = !full;
  assign out_valid = !empty;
  assign push     = in_valid && !full;
  assign pop      = out_ready && !empty;

  // Head entry is shown straight from storage (first-word fall-through).
  assign out_result = mem_q[rptr_q][12:5];
  assign out_flags  = mem_q[rptr_q][4:0];
  assign fflags     = fflags_q;
  assign count      = count_q;
  assign trap       = |(fflags_q & trap_en);

  // Next-state for pointers, occupancy, sticky flags and counter.
  always_comb begin
    wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = pop  ? rptr_q + AW'(1) : rptr_q;
    occ_d    = occ_q;
    if (push && !pop) occ_d = occ_q + (AW+1)'(1);
    else if (pop && !push) occ_d = occ_q - (AW+1)'(1);

    // A push in the clearing cycle still contributes its flags.
    if (fflags_clr) fflags_d = push ? in_flags : 5'b0;
    else            fflags_d = fflags_q | (push ? in_flags : 5'b0);

    count_d = count_q;
    if (cnt_clr) count_d = push ? CNT_W'(1) : '0;
    else if (push && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  // Control state: asynchronous reset discards queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      occ_q    <= '0;
      fflags_q <= '0;
      count_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      occ_q    <= occ_d;
      fflags_q <= fflags_d;
      count_q  <= count_d;
    end
  end

  // Storage write; entries are written once on push and never touched again.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {in_result, in_flags};
  end

endmodule

// File: tb/tb_fp8_mult_collect.sv
// Testbench for fp8_mult_collect: queue-based reference model, randomized
// and directed scenarios, one task per scenario.
module tb_fp8_mult_collect;

  localparam int DEPTH = 4;
  localparam int CMAX  = 65535;

  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0, out_ready = 0, fflags_clr = 0, cnt_clr = 0;
  logic [7:0] in_result = 0;
  logic [4:0] in_flags = 0, trap_en = 0;
  logic in_ready, out_valid, trap;
  logic [7:0] out_result;
  logic [4:0] out_flags, fflags;
  logic [15:0] count;

  // Second instance with a 2-bit counter for saturation checks
  logic in_valid2 = 0, cnt_clr2 = 0;
  logic [7:0] in_result2 = 0;
  logic in_ready2, out_valid2, trap2;
  logic [7:0] out_result2;
  logic [4:0] out_flags2, fflags2;
  logic [1:0] count2;

  int chk = 0;
  int pass = 0;

  logic [12:0] mq[$];
  logic [4:0]  m_fflags;
  int          m_count;

  always #5 clk = ~clk;

  fp8_mult_collect #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .fflags(fflags), .fflags_clr(fflags_clr), .trap_en(trap_en), .trap(trap),
    .count(count), .cnt_clr(cnt_clr)
  );

  fp8_mult_collect #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_result(in_result2), .in_flags(5'b00001),
    .out_valid(out_valid2), .out_ready(1'b1), .out_result(out_result2), .out_flags(out_flags2),
    .fflags(fflags2), .fflags_clr(1'b0), .trap_en(5'b00000), .trap(trap2),
    .count(count2), .cnt_clr(cnt_clr2)
  );

  // Advance one clock and update the reference model from the held inputs.
  task automatic step();
    bit acc, pp;
    acc = in_valid && (mq.size() < DEPTH);
    pp  = out_ready && (mq.size() > 0);
    @(posedge clk); #1;
    if (pp) void'(mq.pop_front());
    if (acc) mq.push_back({in_result, in_flags});
    if (fflags_clr) m_fflags = acc ? in_flags : 5'b0;
    else if (acc)   m_fflags = m_fflags | in_flags;
    if (cnt_clr) m_count = acc ? 1 : 0;
    else if (acc && m_count < CMAX) m_count = m_count + 1;
  endtask

  task automatic apply_reset();
    in_valid = 0; out_ready = 0; fflags_clr = 0; cnt_clr = 0; trap_en = 0;
    in_valid2 = 0; cnt_clr2 = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    mq.delete(); m_fflags = 0; m_count = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    trap_en = 5'b11111;
    #1;
    chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass++;
    chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass++;
    chk++; if (fflags !== 5'b0) $display("FAIL reset_fflags: got %b want 00000", fflags); else pass++;
    chk++; if (trap !== 1'b0) $display("FAIL reset_trap: got %b want 0", trap); else pass++;
    chk++; if (count !== 16'd0) $display("FAIL reset_count: got %0d want 0", count); else pass++;
    chk++; if (count2 !== 2'd0) $display("FAIL reset_count2: got %0d want 0", count2); else pass++;
    trap_en = 0;
  endtask

  task automatic test_single();
    apply_reset();
    chk++; if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b want 1", in_ready); else pass++;
    in_valid = 1; in_result = 8'h38; in_flags = 5'b00001;
    step();
    in_valid = 0;
    chk++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", out_valid); else pass++;
    chk++; if (out_result !== 8'h38) $display("FAIL single_result: got %h want 38", out_result); else pass++;
    chk++; if (out_flags !== 5'b00001) $display("FAIL single_flags: got %b want 00001", out_flags); else pass++;
    chk++; if (fflags !== 5'b00001) $display("FAIL single_fflags: got %b want 00001", fflags); else pass++;
    chk++; if (count !== 16'd1) $display("FAIL single_count: got %0d want 1", count); else pass++;
    out_ready = 1;
    step();
    out_ready = 0;
    chk++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", out_valid); else pass++;
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    apply_reset();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_result = vals[i]; in_flags = 5'($urandom_range(0, 31));
      step();
    end
    chk++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else pass++;
    in_result = 8'h99;
    step();
    in_valid = 0;
    chk++; if (count !== 16'd4) $display("FAIL fill_count: got %0d want 4", count); else pass++;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk++; if (out_valid !== 1'b1 || out_result !== vals[i])
        $display("FAIL drain_%0d: got v=%b %h want v=1 %h", i, out_valid, out_result, vals[i]);
      else pass++;
      chk++; if (out_flags !== mq[0][4:0])
        $display("FAIL drain_flags_%0d: got %b want %b", i, out_flags, mq[0][4:0]);
      else pass++;
      step();
    end
    out_ready = 0;
    chk++; if (out_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", out_valid); else pass++;
  endtask

  task automatic test_full_simul();
    logic [7:0] exp_order [5];
    exp_order[0] = 8'h11; exp_order[1] = 8'h22; exp_order[2] = 8'h33;
    exp_order[3] = 8'h44; exp_order[4] = 8'h55;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_result = exp_order[i]; in_flags = 0;
      step();
    end
    in_valid = 1; in_result = 8'h55; in_flags = 5'b00010; out_ready = 1;
    chk++; if (out_result !== 8'h11) $display("FAIL fullsim_head: got %h want 11", out_result); else pass++;
    step();
    chk++; if (in_ready !== 1'b1) $display("FAIL fullsim_in_ready: got %b want 1", in_ready); else pass++;
    chk++; if (count !== 16'd4) $display("FAIL fullsim_nopush: got %0d want 4", count); else pass++;
    chk++; if (out_result !== 8'h22) $display("FAIL fullsim_next: got %h want 22", out_result); else pass++;
    out_ready = 0;
    step();
    in_valid = 0;
    chk++; if (count !== 16'd5) $display("FAIL fullsim_pending: got %0d want 5", count); else pass++;
    out_ready = 1;
    for (int i = 1; i < 5; i++) begin
      chk++; if (out_valid !== 1'b1 || out_result !== exp_order[i])
        $display("FAIL fullsim_order_%0d: got %h want %h", i, out_result, exp_order[i]);
      else pass++;
      step();
    end
    out_ready = 0;
  endtask

  task automatic test_streaming();
    apply_reset();
    out_ready = 1;
    for (int i = 0; i < 11; i++) begin
      in_valid = (i < 10);
      in_result = 8'($urandom); in_flags = 5'($urandom);
      chk++; if (out_valid !== (mq.size() > 0))
        $display("FAIL stream_valid_%0d: got %b want %b", i, out_valid, mq.size() > 0);
      else pass++;
      if (mq.size() > 0) begin
        chk++; if ({out_result, out_flags} !== mq[0])
          $display("FAIL stream_data_%0d: got %h want %h", i, {out_result, out_flags}, mq[0]);
        else pass++;
      end
      step();
    end
    in_valid = 0;
    chk++; if (count !== 16'd10) $display("FAIL stream_count: got %0d want 10", count); else pass++;
    chk++; if (out_valid !== 1'b0) $display("FAIL stream_end: got %b want 0", out_valid); else pass++;
    out_ready = 0;
  endtask

  task automatic test_sticky_trap();
    apply_reset();
    trap_en = 5'b00100; out_ready = 1;
    in_valid = 1; in_result = 8'h38; in_flags = 5'b00001;
    step();
    chk++; if (trap !== 1'b0) $display("FAIL trap_first: got %b want 0", trap); else pass++;
    in_result = 8'h70; in_flags = 5'b00100;
    step();
    chk++; if (trap !== 1'b1) $display("FAIL trap_second: got %b want 1", trap); else pass++;
    chk++; if (fflags !== 5'b00101) $display("FAIL fflags_sticky: got %b want 00101", fflags); else pass++;
    in_result = 8'h01; in_flags = 5'b10000; fflags_clr = 1;
    step();
    fflags_clr = 0; in_valid = 0;
    chk++; if (fflags !== 5'b10000) $display("FAIL fflags_clr: got %b want 10000", fflags); else pass++;
    chk++; if (trap !== 1'b0) $display("FAIL trap_clr: got %b want 0", trap); else pass++;
    out_ready = 0; trap_en = 0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    trap_en = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_result = 8'(i + 1); in_flags = 5'b11111;
      step();
    end
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else pass++;
    chk++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else pass++;
    chk++; if (fflags !== 5'b0) $display("FAIL rstmid_fflags: got %b want 0", fflags); else pass++;
    chk++; if (count !== 16'd0) $display("FAIL rstmid_count: got %0d want 0", count); else pass++;
    chk++; if (trap !== 1'b0) $display("FAIL rstmid_trap: got %b want 0", trap); else pass++;
    @(posedge clk); #1;
    rst_n = 1;
    mq.delete(); m_fflags = 0; m_count = 0; trap_en = 0;
  endtask

  task automatic test_saturation();
    int exp2;
    apply_reset();
    exp2 = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1; in_result2 = 8'(i);
      @(posedge clk); #1;
      if (exp2 < 3) exp2++;
      chk++; if (count2 !== 2'(exp2)) $display("FAIL sat_count_%0d: got %0d want %0d", i, count2, exp2); else pass++;
    end
    cnt_clr2 = 1;
    @(posedge clk); #1;
    cnt_clr2 = 0; in_valid2 = 0;
    chk++; if (count2 !== 2'd1) $display("FAIL sat_clr: got %0d want 1", count2); else pass++;
  endtask

  task automatic test_random();
    apply_reset();
    trap_en = 5'($urandom);
    for (int i = 0; i < 300; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_result  = 8'($urandom);
      in_flags   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      fflags_clr = ($urandom_range(0, 20) == 0);
      cnt_clr    = ($urandom_range(0, 40) == 0);
      chk++; if (in_ready !== (mq.size() < DEPTH))
        $display("FAIL rnd_in_ready_%0d: got %b want %b", i, in_ready, mq.size() < DEPTH);
      else pass++;
      chk++; if (out_valid !== (mq.size() > 0))
        $display("FAIL rnd_out_valid_%0d: got %b want %b", i, out_valid, mq.size() > 0);
      else pass++;
      if (mq.size() > 0) begin
        chk++; if ({out_result, out_flags} !== mq[0])
          $display("FAIL rnd_data_%0d: got %h want %h", i, {out_result, out_flags}, mq[0]);
        else pass++;
      end
      chk++; if (fflags !== m_fflags) $display("FAIL rnd_fflags_%0d: got %b want %b", i, fflags, m_fflags); else pass++;
      chk++; if (trap !== |(m_fflags & trap_en)) $display("FAIL rnd_trap_%0d: got %b want %b", i, trap, |(m_fflags & trap_en)); else pass++;
      chk++; if (count !== 16'(m_count)) $display("FAIL rnd_count_%0d: got %0d want %0d", i, count, m_count); else pass++;
      step();
    end
    in_valid = 0; out_ready = 0; fflags_clr = 0; cnt_clr = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_simul();
    test_streaming();
    test_sticky_trap();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
